// File: rtl/hist_tracker_arbiter.sv
// rtl/hist_tracker_arbiter.sv - round-robin arbiter sharing one history tracker
//
// Grants one requester at a time, drives its value onto the tracker's data
// input for HOLD_CYC cycles, snapshots the tracker's four history entries and
// acknowledges with a hit flag evaluated at grant time.
//
// Ports:
//   clk_in          clock, rising edge
//   reset_in        asynchronous, active-high reset
//   req_in          per-requester request level
//   req_data_in     requester i value at [i*DATA_W +: DATA_W]
//   gnt_out         one-hot grant, high DRIVE through ACK
//   ack_out         one-cycle completion pulse
//   hit_out         granted value was already in the history (valid with ack_out)
//   hist_out        tracker out_0..out_3 snapshot, entry k at [k*DATA_W +: DATA_W]
//   hist_valid_out  tracker valid-bit snapshot
//   busy_out        high whenever a transaction is in progress
//   trk_data_out    tracker data_in; changes only on a grant
//   trk_out_in      tracker out_0..out_3
//   trk_valid_in    tracker out_valid_0..3

module hist_tracker_arbiter #(
  parameter int DATA_W   = 8,
  parameter int N_REQ    = 4,
  parameter int HOLD_CYC = 3
) (
  input  logic                  clk_in,
  input  logic                  reset_in,
  input  logic [N_REQ-1:0]      req_in,
  input  logic [N_REQ*DATA_W-1:0] req_data_in,
  output logic [N_REQ-1:0]      gnt_out,
  output logic                  ack_out,
  output logic                  hit_out,
  output logic [4*DATA_W-1:0]   hist_out,
  output logic [3:0]            hist_valid_out,
  output logic                  busy_out,
  output logic [DATA_W-1:0]     trk_data_out,
  input  logic [4*DATA_W-1:0]   trk_out_in,
  input  logic [3:0]            trk_valid_in
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  // One extra bit so rr_ptr + offset never wraps before the modulo fold.
  localparam int CW    = IDX_W + 1;
  // Wide enough to hold HOLD_CYC-1.
  localparam int CNT_W = (HOLD_CYC > 2) ? $clog2(HOLD_CYC) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    ACK    = 2'd3
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] gnt_idx;
  logic [CNT_W-1:0] hold_cnt;
  logic             hit_q;

  logic [IDX_W-1:0] sel_idx;
  logic             sel_found;
  logic [CW-1:0]    cand;
  logic [DATA_W-1:0] sel_data;
  logic             sel_hit;
  logic [N_REQ-1:0] gnt_next;

  // Rotating search: first set request at rr_ptr, rr_ptr+1, ... mod N_REQ.
  always_comb begin
    sel_idx   = '0;
    sel_found = 1'b0;
    cand      = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = {1'b0, rr_ptr} + CW'(i);
      if (cand >= CW'(N_REQ)) begin
        cand = cand - CW'(N_REQ);
      end
      if (!sel_found && req_in[cand[IDX_W-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = cand[IDX_W-1:0];
      end
    end
  end

  // Constant-index mux keeps the data select free of computed part-selects.
  always_comb begin
    sel_data = '0;
    gnt_next = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (sel_idx == IDX_W'(i)) begin
        sel_data    = req_data_in[i*DATA_W +: DATA_W];
        gnt_next[i] = 1'b1;
      end
    end
  end

  // Hit is judged against the history as it stands in the grant cycle,
  // before the tracker has seen the new value.
  always_comb begin
    sel_hit = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (trk_valid_in[k] && (trk_out_in[k*DATA_W +: DATA_W] == sel_data)) begin
        sel_hit = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state          <= IDLE;
      rr_ptr         <= '0;
      gnt_idx        <= '0;
      hold_cnt       <= '0;
      hit_q          <= 1'b0;
      gnt_out        <= '0;
      ack_out        <= 1'b0;
      hit_out        <= 1'b0;
      hist_out       <= '0;
      hist_valid_out <= '0;
      busy_out       <= 1'b0;
      trk_data_out   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (sel_found) begin
            gnt_idx      <= sel_idx;
            gnt_out      <= gnt_next;
            trk_data_out <= sel_data;
            hit_q        <= sel_hit;
            hold_cnt     <= CNT_W'(HOLD_CYC - 1);
            busy_out     <= 1'b1;
            state        <= DRIVE;
          end
        end
        DRIVE: begin
          if (hold_cnt == '0) begin
            state <= SAMPLE;
          end else begin
            hold_cnt <= hold_cnt - CNT_W'(1);
          end
        end
        SAMPLE: begin
          hist_out       <= trk_out_in;
          hist_valid_out <= trk_valid_in;
          ack_out        <= 1'b1;
          hit_out        <= hit_q;
          state          <= ACK;
        end
        ACK: begin
          ack_out  <= 1'b0;
          hit_out  <= 1'b0;
          gnt_out  <= '0;
          busy_out <= 1'b0;
          rr_ptr   <= (gnt_idx == IDX_W'(N_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hist_tracker_arbiter.sv
// tb/tb_hist_tracker_arbiter.sv - self-checking bench for hist_tracker_arbiter

module tb_hist_tracker_arbiter;

  localparam int DATA_W   = 8;
  localparam int N_REQ    = 4;
  localparam int HOLD_CYC = 3;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  gnt;
  logic        ack;
  logic        hit;
  logic [31:0] hist;
  logic [3:0]  hist_v;
  logic        busy;
  logic [7:0]  trk_data;
  logic [31:0] trk_out;
  logic [3:0]  trk_valid;

  int n_tests = 0;
  int n_fail  = 0;

  hist_tracker_arbiter #(
    .DATA_W  (DATA_W),
    .N_REQ   (N_REQ),
    .HOLD_CYC(HOLD_CYC)
  ) dut (
    .clk_in        (clk),
    .reset_in      (rst),
    .req_in        (req),
    .req_data_in   (req_data),
    .gnt_out       (gnt),
    .ack_out       (ack),
    .hit_out       (hit),
    .hist_out      (hist),
    .hist_valid_out(hist_v),
    .busy_out      (busy),
    .trk_data_out  (trk_data),
    .trk_out_in    (trk_out),
    .trk_valid_in  (trk_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment stand-in for the history tracker: when data_in changes to a
  // value not already held, it is pushed in as the newest entry (out_0).
  logic [7:0] tm_val [4];
  logic [3:0] tm_v;
  logic [7:0] tm_last;

  function automatic logic tm_has(input logic [7:0] v);
    for (int k = 0; k < 4; k++) begin
      if (tm_v[k] && tm_val[k] == v) return 1'b1;
    end
    return 1'b0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) tm_val[k] <= 8'h00;
      tm_v    <= 4'h0;
      tm_last <= 8'h00;
    end else if (trk_data != tm_last) begin
      tm_last <= trk_data;
      if (!tm_has(trk_data)) begin
        tm_val[0] <= trk_data;
        tm_val[1] <= tm_val[0];
        tm_val[2] <= tm_val[1];
        tm_val[3] <= tm_val[2];
        tm_v      <= {tm_v[2:0], 1'b1};
      end
    end
  end

  assign trk_out   = {tm_val[3], tm_val[2], tm_val[1], tm_val[0]};
  assign trk_valid = tm_v;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    req      = 4'h0;
    req_data = 32'h0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Starts in IDLE; runs one transaction and ends in the IDLE cycle after ACK.
  task automatic do_txn(input logic [3:0] r, input logic [31:0] d,
                        input logic [3:0] eg, input logic [7:0] ed, input logic eh,
                        input logic [31:0] ehist, input logic [3:0] ev, input string tag);
    int n;
    logic got;
    req      = r;
    req_data = d;
    @(posedge clk); #1;
    chk({tag, " gnt"}, 64'(gnt), 64'(eg));
    chk({tag, " busy"}, 64'(busy), 64'd1);
    chk({tag, " trk_data"}, 64'(trk_data), 64'(ed));
    chk({tag, " ack_early"}, 64'(ack), 64'd0);
    n   = 0;
    got = 1'b0;
    while (!got && n < 20) begin
      @(posedge clk); #1;
      n++;
      if (ack) got = 1'b1;
    end
    chk({tag, " ack_latency"}, got ? 64'(n) : 64'd99, 64'(HOLD_CYC + 1));
    chk({tag, " hit"}, 64'(hit), 64'(eh));
    chk({tag, " hist"}, 64'(hist), 64'(ehist));
    chk({tag, " hist_valid"}, 64'(hist_v), 64'(ev));
    chk({tag, " gnt_at_ack"}, 64'(gnt), 64'(eg));
    chk({tag, " trk_data_at_ack"}, 64'(trk_data), 64'(ed));
    @(posedge clk); #1;
    chk({tag, " idle_busy"}, 64'(busy), 64'd0);
    chk({tag, " idle_gnt"}, 64'(gnt), 64'd0);
    chk({tag, " idle_ack"}, 64'(ack), 64'd0);
  endtask

  typedef struct {
    logic [3:0]  r;
    logic [31:0] d;
    logic [3:0]  eg;
    logic [7:0]  ed;
    logic        eh;
    logic [31:0] ehist;
    logic [3:0]  ev;
  } vec_t;

  vec_t tbl [8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  rr_gnt [5];
    int          rr_cyc [5];
    int          nacks;
    int          rr;
    int          g;
    logic [3:0]  mask;
    logic [3:0]  nb;
    logic [7:0]  dat [4];
    logic [7:0]  q [$];
    logic [31:0] d;
    logic [31:0] ehist;
    logic [3:0]  ev;
    logic        eh;
    logic        got;
    int          n;

    tbl[0] = '{4'b0001, 32'h0000005A, 4'b0001, 8'h5A, 1'b0, 32'h0000005A, 4'b0001};
    tbl[1] = '{4'b0100, 32'h00110000, 4'b0100, 8'h11, 1'b0, 32'h00005A11, 4'b0011};
    tbl[2] = '{4'b0100, 32'h00110000, 4'b0100, 8'h11, 1'b1, 32'h00005A11, 4'b0011};
    tbl[3] = '{4'b0100, 32'h00220000, 4'b0100, 8'h22, 1'b0, 32'h005A1122, 4'b0111};
    tbl[4] = '{4'b0101, 32'h0033005A, 4'b0001, 8'h5A, 1'b1, 32'h005A1122, 4'b0111};
    tbl[5] = '{4'b1010, 32'h55004400, 4'b0010, 8'h44, 1'b0, 32'h5A112244, 4'b1111};
    tbl[6] = '{4'b1010, 32'h55004400, 4'b1000, 8'h55, 1'b0, 32'h11224455, 4'b1111};
    tbl[7] = '{4'b1111, 32'h04030201, 4'b0001, 8'h01, 1'b0, 32'h22445501, 4'b1111};

    // Reset state
    rst      = 1'b1;
    req      = 4'h0;
    req_data = 32'h0;
    @(posedge clk); #1;
    chk("rst gnt", 64'(gnt), 64'd0);
    chk("rst ack", 64'(ack), 64'd0);
    chk("rst hit", 64'(hit), 64'd0);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst trk_data", 64'(trk_data), 64'd0);
    chk("rst hist", 64'(hist), 64'd0);
    chk("rst hist_valid", 64'(hist_v), 64'd0);
    rst = 1'b0;

    // Table: single transactions, hits, pointer after partial service
    for (int i = 0; i < 8; i++) begin
      do_txn(tbl[i].r, tbl[i].d, tbl[i].eg, tbl[i].ed, tbl[i].eh,
             tbl[i].ehist, tbl[i].ev, $sformatf("tbl%0d", i));
    end

    // Continuous 1111: grant order 0,1,2,3,0 with acks HOLD_CYC+3 apart
    do_reset();
    for (int i = 0; i < 5; i++) begin
      rr_gnt[i] = 4'h0;
      rr_cyc[i] = 0;
    end
    req      = 4'b1111;
    req_data = 32'h40302010;
    nacks    = 0;
    for (int c = 1; c <= 60 && nacks < 5; c++) begin
      @(posedge clk); #1;
      if (ack) begin
        rr_gnt[nacks] = gnt;
        rr_cyc[nacks] = c;
        nacks++;
      end
    end
    req = 4'h0;
    chk("rr ack_count", 64'(nacks), 64'd5);
    chk("rr first_ack", 64'(rr_cyc[0]), 64'(HOLD_CYC + 2));
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("rr gnt%0d", i), 64'(rr_gnt[i]), 64'(4'b0001 << (i % 4)));
    end
    for (int i = 1; i < 5; i++) begin
      chk($sformatf("rr spacing%0d", i), 64'(rr_cyc[i] - rr_cyc[i-1]), 64'(HOLD_CYC + 3));
    end

    // Data change after grant is ignored
    do_reset();
    req      = 4'b0010;
    req_data = 32'h00003300;
    @(posedge clk); #1;
    chk("dchg gnt", 64'(gnt), 64'b0010);
    chk("dchg trk_data", 64'(trk_data), 64'h33);
    req_data = 32'h00004400;
    n   = 0;
    got = 1'b0;
    while (!got && n < 20) begin
      @(posedge clk); #1;
      n++;
      chk("dchg trk_hold", 64'(trk_data), 64'h33);
      if (ack) got = 1'b1;
    end
    chk("dchg ack_seen", 64'(got), 64'd1);
    chk("dchg hit", 64'(hit), 64'd0);
    chk("dchg hist", 64'(hist), 64'h00000033);
    req = 4'h0;

    // Reset during DRIVE: immediate clear, no ack, then fresh arbitration
    do_reset();
    req      = 4'b0001;
    req_data = 32'h0000005A;
    @(posedge clk); #1;
    chk("mrst gnt_before", 64'(gnt), 64'b0001);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("mrst gnt", 64'(gnt), 64'd0);
    chk("mrst ack", 64'(ack), 64'd0);
    chk("mrst hit", 64'(hit), 64'd0);
    chk("mrst busy", 64'(busy), 64'd0);
    chk("mrst trk_data", 64'(trk_data), 64'd0);
    chk("mrst hist", 64'(hist), 64'd0);
    chk("mrst hist_valid", 64'(hist_v), 64'd0);
    req      = 4'b1000;
    req_data = 32'h77000000;
    @(posedge clk); #1;
    chk("mrst ack_in_reset", 64'(ack), 64'd0);
    rst = 1'b0;
    do_txn(4'b1000, 32'h77000000, 4'b1000, 8'h77, 1'b0, 32'h00000077, 4'b0001, "post_rst");

    // Randomised traffic against a list-based reference model
    do_reset();
    rr   = 0;
    mask = 4'h0;
    q.delete();
    for (int i = 0; i < 4; i++) dat[i] = 8'h00;
    for (int it = 0; it < 40; it++) begin
      nb = 4'($urandom_range(0, 15));
      for (int i = 0; i < 4; i++) begin
        if (nb[i] && !mask[i]) begin
          dat[i]  = 8'($urandom_range(1, 12));
          mask[i] = 1'b1;
        end
      end
      if (mask == 4'h0) begin
        g       = int'($urandom_range(0, 3));
        dat[g]  = 8'($urandom_range(1, 12));
        mask[g] = 1'b1;
      end
      g = -1;
      for (int k = 0; k < 4; k++) begin
        if (g < 0 && mask[(rr + k) % 4]) g = (rr + k) % 4;
      end
      eh = 1'b0;
      foreach (q[j]) if (q[j] == dat[g]) eh = 1'b1;
      if (!eh) begin
        q.push_front(dat[g]);
        if (q.size() > 4) void'(q.pop_back());
      end
      ehist = 32'h0;
      ev    = 4'h0;
      for (int j = 0; j < q.size(); j++) begin
        ehist[j*8 +: 8] = q[j];
        ev[j]           = 1'b1;
      end
      d = 32'h0;
      for (int i = 0; i < 4; i++) d[i*8 +: 8] = dat[i];
      do_txn(mask, d, 4'(4'b0001 << g), dat[g], eh, ehist, ev, $sformatf("rand%0d", it));
      rr      = (g + 1) % 4;
      mask[g] = 1'b0;
    end
    req = 4'h0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
